// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states,
// combiner unit-select codes and flag bit positions.
package alu_seq_pkg;

    localparam logic [2:0] OP_BADD = 3'd0;
    localparam logic [2:0] OP_BLOG = 3'd1;
    localparam logic [2:0] OP_BSHF = 3'd2;
    localparam logic [2:0] OP_WADD = 3'd3;
    localparam logic [2:0] OP_WLOG = 3'd4;
    localparam logic [2:0] OP_WSHF = 3'd5;
    localparam logic [2:0] OP_HSHF = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_PASS_LO = 3'd2,
        S_PASS_HI = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    localparam logic [1:0] U_LOGIC = 2'b00;
    localparam logic [1:0] U_ADD   = 2'b01;
    localparam logic [1:0] U_SHFT  = 2'b10;

    localparam int F_C   = 5;
    localparam int F_H   = 4;
    localparam int F_S   = 3;
    localparam int F_Z   = 2;
    localparam int F_P   = 1;
    localparam int F_ONE = 0;

    // Combiner unit used by a single-pass opcode; illegal opcode keeps the combiner idle.
    function automatic logic [1:0] exec_unit(input logic [2:0] op);
        case (op)
            OP_BADD, OP_WADD: exec_unit = U_ADD;
            OP_BSHF, OP_HSHF: exec_unit = U_SHFT;
            default:          exec_unit = U_LOGIC;
        endcase
    endfunction

endpackage

// File: rtl/alu_flagreg.sv
// Six-bit flag register. Loads all flags on a single pass, and for the
// two-pass word shift chains carry, zero and one from the low pass into
// the high-pass result.
module alu_flagreg
    import alu_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ld_exec_i,
    input  logic       ld_lo_i,
    input  logic       ld_hi_i,
    input  logic [5:0] nxt_i,
    output logic [5:0] flags_o,
    output logic       carry_o
);

    logic [5:0] flags_q, flags_d;
    logic       carry_q, lo_zero_q, lo_one_q;

    // Select the flag load for the current pass
    always_comb begin
        flags_d = flags_q;
        if (ld_exec_i) begin
            flags_d = nxt_i;
        end else if (ld_hi_i) begin
            flags_d[F_C]   = nxt_i[F_C];
            flags_d[F_H]   = 1'b0;
            flags_d[F_S]   = nxt_i[F_S];
            flags_d[F_Z]   = lo_zero_q & nxt_i[F_Z];
            flags_d[F_P]   = nxt_i[F_P];
            // The word equals one only if the low byte is one and the high byte is zero
            flags_d[F_ONE] = lo_one_q & nxt_i[F_Z];
        end
    end

    // Flag and low-pass chaining registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q   <= '0;
            carry_q   <= 1'b0;
            lo_zero_q <= 1'b0;
            lo_one_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            if (ld_lo_i) begin
                carry_q   <= nxt_i[F_C];
                lo_zero_q <= nxt_i[F_Z];
                lo_one_q  <= nxt_i[F_ONE];
            end
        end
    end

    assign flags_o = flags_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/alu_seq.sv
// ALU sequencer: accepts one request at a time, drives the function-unit
// combiner for one pass (or two byte passes for a word shift), captures
// the result and flags, and pulses done (with err for the illegal opcode).
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clkc,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  req_op,
    input  logic        flush,
    input  logic [15:0] data_bus,
    input  logic        cry_nxt,
    input  logic        hcar_nxt,
    input  logic        sign_nxt,
    input  logic        zero_nxt,
    input  logic        par_nxt,
    input  logic        one_nxt,
    output logic [1:0]  unit_sel,
    output logic        word_op,
    output logic        hi_byte,
    output logic        byte_sel,
    output logic        shft_cin,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic [5:0]  flags
);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [15:0] result_q, result_d;
    logic        cap_exec, cap_lo, cap_hi;
    logic        carry;
    logic [5:0]  nxt_flags;

    // A flush in the capture cycle leaves result and flags untouched
    assign cap_exec  = (state_q == S_EXEC) && !flush && (op_q != OP_ILL);
    assign cap_lo    = (state_q == S_PASS_LO) && !flush;
    assign cap_hi    = (state_q == S_PASS_HI) && !flush;
    assign nxt_flags = {cry_nxt, hcar_nxt, sign_nxt, zero_nxt, par_nxt, one_nxt};

    // Sequencing FSM; flush returns to IDLE from anywhere and blocks acceptance in IDLE
    always_ff @(posedge clkc or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_BADD;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= req_op;
                        state_q <= (req_op == OP_WSHF) ? S_PASS_LO : S_EXEC;
                    end
                end
                S_EXEC:    state_q <= S_FIN;
                S_PASS_LO: state_q <= S_PASS_HI;
                S_PASS_HI: state_q <= S_FIN;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Result next value: whole word on a single pass, one byte per shift pass
    always_comb begin
        result_d = result_q;
        if (cap_exec) begin
            result_d = data_bus;
        end else if (cap_lo) begin
            result_d[7:0] = data_bus[7:0];
        end else if (cap_hi) begin
            result_d[15:8] = data_bus[7:0];
        end
    end

    // Result register
    always_ff @(posedge clkc or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    alu_flagreg u_flagreg (
        .clk_i     (clkc),
        .rst_i     (reset),
        .ld_exec_i (cap_exec),
        .ld_lo_i   (cap_lo),
        .ld_hi_i   (cap_hi),
        .nxt_i     (nxt_flags),
        .flags_o   (flags),
        .carry_o   (carry)
    );

    // Combiner controls decoded from registered state and opcode only
    always_comb begin
        unit_sel = U_LOGIC;
        word_op  = 1'b0;
        hi_byte  = 1'b0;
        byte_sel = 1'b0;
        shft_cin = 1'b0;
        case (state_q)
            S_EXEC: begin
                unit_sel = exec_unit(op_q);
                word_op  = (op_q == OP_WADD) || (op_q == OP_WLOG);
                hi_byte  = (op_q == OP_HSHF);
            end
            S_PASS_LO: begin
                unit_sel = U_SHFT;
                shft_cin = flags[F_C];
            end
            S_PASS_HI: begin
                unit_sel = U_SHFT;
                byte_sel = 1'b1;
                shft_cin = carry;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_FIN) && !flush;
    assign err    = done && (op_q == OP_ILL);
    assign result = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq with a transaction-level reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clkc = 1'b0;
    logic        reset, req, flush;
    logic [2:0]  req_op;
    logic [15:0] data_bus;
    logic        cry_nxt, hcar_nxt, sign_nxt, zero_nxt, par_nxt, one_nxt;
    logic [1:0]  unit_sel;
    logic        word_op, hi_byte, byte_sel, shft_cin, busy, done, err;
    logic [15:0] result;
    logic [5:0]  flags;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_res;
    logic [5:0]  exp_flg;

    always #5 clkc = ~clkc;

    alu_seq dut (
        .clkc     (clkc),
        .reset    (reset),
        .req      (req),
        .req_op   (req_op),
        .flush    (flush),
        .data_bus (data_bus),
        .cry_nxt  (cry_nxt),
        .hcar_nxt (hcar_nxt),
        .sign_nxt (sign_nxt),
        .zero_nxt (zero_nxt),
        .par_nxt  (par_nxt),
        .one_nxt  (one_nxt),
        .unit_sel (unit_sel),
        .word_op  (word_op),
        .hi_byte  (hi_byte),
        .byte_sel (byte_sel),
        .shft_cin (shft_cin),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .flags    (flags)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkc);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [5:0] f);
        data_bus = d;
        {cry_nxt, hcar_nxt, sign_nxt, zero_nxt, par_nxt, one_nxt} = f;
    endtask

    // Control vector: {unit_sel, word_op, hi_byte, byte_sel, shft_cin, busy, done, err}
    function automatic logic [15:0] ctl_now();
        return 16'({unit_sel, word_op, hi_byte, byte_sel, shft_cin, busy, done, err});
    endfunction

    function automatic logic [1:0] ref_unit(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd3) return 2'b01;
        if (op == 3'd2 || op == 3'd6) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk_state(input string tag, input logic [8:0] ctl);
        chk({tag, ".ctl"}, ctl_now(), 16'(ctl));
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".flg"}, 16'(flags), 16'(exp_flg));
    endtask

    // One transaction; flush_ph selects the phase to flush (nph = FIN, -1 = none)
    task automatic run_op(input logic [2:0] op, input int flush_ph,
                          input logic [15:0] d0, input logic [5:0] f0,
                          input logic [15:0] d1, input logic [5:0] f1);
        int         nph;
        logic       cm, lz, lo, is_fl;
        logic [1:0] u;
        logic       w, h, b, c;
        nph = (op == 3'd5) ? 2 : 1;
        cm = 1'b0; lz = 1'b0; lo = 1'b0;
        req = 1'b1; req_op = op; flush = 1'b0;
        tick();
        for (int ph = 0; ph < nph; ph++) begin
            req = 1'($urandom);
            req_op = 3'($urandom);
            if (ph == 0) drive(d0, f0);
            else         drive(d1, f1);
            is_fl = (ph == flush_ph);
            flush = is_fl;
            #1;
            if (nph == 2) begin
                u = 2'b10; w = 1'b0; h = 1'b0; b = (ph == 1);
                c = (ph == 0) ? exp_flg[5] : cm;
            end else begin
                u = ref_unit(op); w = (op == 3'd3 || op == 3'd4); h = (op == 3'd6);
                b = 1'b0; c = 1'b0;
            end
            chk_state("pass", {u, w, h, b, c, 1'b1, 1'b0, 1'b0});
            tick();
            if (is_fl) begin
                flush = 1'b0; req = 1'b0;
                #1;
                chk_state("flushed", 9'b0);
                return;
            end
            if (nph == 1) begin
                if (op != 3'd7) begin
                    exp_res = d0;
                    exp_flg = f0;
                end
            end else if (ph == 0) begin
                exp_res[7:0] = d0[7:0];
                cm = f0[5]; lz = f0[2]; lo = f0[0];
            end else begin
                exp_res[15:8] = d1[7:0];
                exp_flg = {f1[5], 1'b0, f1[3], lz & f1[2], f1[1], lo & f1[2]};
            end
        end
        // FIN: a stray req must be ignored
        req = 1'($urandom); req_op = 3'($urandom);
        drive(16'($urandom), 6'($urandom));
        is_fl = (flush_ph == nph);
        flush = is_fl;
        #1;
        chk_state("fin", {2'b00, 4'b0000, 1'b1, !is_fl, (op == 3'd7) && !is_fl});
        tick();
        req = 1'b0; flush = 1'b0;
        #1;
        chk_state("idle", 9'b0);
    endtask

    initial begin
        int op, fp;
        reset = 1'b1; req = 1'b0; req_op = 3'd0; flush = 1'b0;
        drive(16'h0, 6'h0);
        exp_res = '0; exp_flg = '0;
        tick();
        chk_state("reset", 9'b0);
        #2 reset = 1'b0;
        tick();
        chk_state("post_reset", 9'b0);

        // BADD, then word shift with carry-in 1 from the BADD flags
        run_op(3'd0, -1, 16'h0080, 6'b101000, 16'h0, 6'h0);
        chk("badd.flags", 16'(flags), 16'h0028);
        run_op(3'd5, -1, 16'h0000, 6'b100100, 16'h0001, 6'b000000);
        chk("wshf.res", result, 16'h0100);
        run_op(3'd6, -1, 16'h5555, 6'($urandom), 16'h0, 6'h0);
        chk("hshf.res", result, 16'h5555);
        run_op(3'd7, -1, 16'($urandom), 6'($urandom), 16'h0, 6'h0);
        run_op(3'd5, 0, 16'($urandom), 6'($urandom), 16'($urandom), 6'($urandom));
        run_op(3'd5, 1, 16'($urandom), 6'($urandom), 16'($urandom), 6'($urandom));
        run_op(3'd2, 1, 16'($urandom), 6'($urandom), 16'h0, 6'h0);
        run_op(3'd3, 0, 16'($urandom), 6'($urandom), 16'h0, 6'h0);

        // req together with flush in IDLE is not accepted
        req = 1'b1; req_op = 3'd0; flush = 1'b1;
        tick();
        req = 1'b0; flush = 1'b0;
        #1;
        chk_state("req_flush", 9'b0);

        // Reset in PASS_HI of a word shift
        run_op(3'd4, -1, 16'hBEEF, 6'b111111, 16'h0, 6'h0);
        req = 1'b1; req_op = 3'd5;
        tick();
        req = 1'b0;
        drive(16'h00AA, 6'b100000);
        tick();
        chk("pass_hi.bsel", 16'(byte_sel), 16'h1);
        #2 reset = 1'b1;
        #1;
        exp_res = '0; exp_flg = '0;
        chk_state("mid_reset", 9'b0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("after_reset", 9'b0);
        end

        // Randomized transactions with occasional idle gaps and flushes
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 7));
            fp = -1;
            if ($urandom_range(0, 7) == 0) fp = int'($urandom_range(0, (op == 5) ? 2 : 1));
            run_op(3'(op), fp, 16'($urandom), 6'($urandom), 16'($urandom), 6'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                drive(16'($urandom), 6'($urandom));
                tick();
                chk_state("gap", 9'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
